// File: rtl/lut_result_writer.sv
// lut_result_writer: packs SIZE_W lookup results into AXI_DATA_W words and writes them as one databus transaction through a 2**DEPTH_W-word FIFO
module lut_result_writer #(
  parameter int DATA_W = 32,
  parameter int SIZE_W = 16,
  parameter int AXI_ADDR_W = 32,
  parameter int AXI_DATA_W = 32,
  parameter int LEN_W = 8,
  parameter int DEPTH_W = 4,
  localparam int DIFF = AXI_DATA_W / SIZE_W,
  localparam int AMT_W = LEN_W + $clog2(DIFF)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    run,
  input  logic                    running,
  input  logic                    disabled,
  input  logic [DATA_W-1:0]       in0,
  input  logic [31:0]             delay0,
  input  logic [AXI_ADDR_W-1:0]   ext_addr,
  input  logic [AMT_W-1:0]        amount,
  output logic                    databus_valid_0,
  input  logic                    databus_ready_0,
  input  logic                    databus_last_0,
  output logic [AXI_ADDR_W-1:0]   databus_addr_0,
  output logic [AXI_DATA_W-1:0]   databus_wdata_0,
  output logic [AXI_DATA_W/8-1:0] databus_wstrb_0,
  output logic [LEN_W-1:0]        databus_len_0,
  input  logic [AXI_DATA_W-1:0]   databus_rdata_0,
  output logic                    done,
  output logic                    overflow,
  output logic                    error
);
  localparam int LW = DIFF > 1 ? $clog2(DIFF) : 1;
  localparam int SB = SIZE_W / 8;
  localparam int STRB_W = AXI_DATA_W / 8;
  localparam int DEPTH = 2 ** DEPTH_W;
  typedef enum logic [1:0] {IDLE, DELAY, CAPTURE, DRAIN} state_t;
  state_t state, state_n;
  logic [AXI_DATA_W-1:0] mem_d [DEPTH];
  logic [STRB_W-1:0] mem_s [DEPTH];
  logic [DEPTH_W:0] wptr, rptr;
  logic [AMT_W-1:0] amt, scnt;
  logic [LEN_W:0] words, bcnt, bcnt_n, words_c;
  logic [31:0] dcnt;
  logic [LW-1:0] lane;
  logic [AXI_DATA_W-1:0] pack, word_c;
  logic [STRB_W-1:0] strb_c;
  logic start, active, empty, full, pop, push, drop, last_s, fin;
  logic unused_ok;
  assign unused_ok = ^{running, databus_rdata_0, in0};
  always_comb begin
    start = run && !disabled && amount != '0;
    active = state == CAPTURE || state == DRAIN;
    empty = wptr == rptr;
    full = (wptr - rptr) == (DEPTH_W+1)'(DEPTH);
    databus_valid_0 = active && !empty;
    databus_wdata_0 = empty ? '0 : mem_d[rptr[DEPTH_W-1:0]];
    databus_wstrb_0 = empty ? '0 : mem_s[rptr[DEPTH_W-1:0]];
    pop = databus_valid_0 && databus_ready_0;
    last_s = scnt == amt - AMT_W'(1);
    push = state == CAPTURE && (lane == LW'(DIFF - 1) || last_s);
    drop = push && full && !pop;
    bcnt_n = bcnt + (LEN_W+1)'(pop) + (LEN_W+1)'(drop);
    fin = active && (pop || drop) && bcnt_n == words;
    words_c = (LEN_W+1)'(({1'b0, amount} + (AMT_W+1)'(DIFF - 1)) >> $clog2(DIFF));
    word_c = pack;
    strb_c = '0;
    for (int i = 0; i < DIFF; i++) begin
      if (LW'(i) == lane) word_c[i*SIZE_W +: SIZE_W] = in0[SIZE_W-1:0];
      if (LW'(i) <= lane) strb_c[i*SB +: SB] = '1;
    end
    state_n = state;
    if (start) state_n = delay0 == 32'd0 ? CAPTURE : DELAY;
    else if (fin) state_n = IDLE;
    else if (state == DELAY && dcnt == 32'd1) state_n = CAPTURE;
    else if (state == CAPTURE && last_s) state_n = DRAIN;
  end
  always_ff @(posedge clk) begin
    if (push && !drop) begin
      mem_d[wptr[DEPTH_W-1:0]] <= word_c;
      mem_s[wptr[DEPTH_W-1:0]] <= strb_c;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      wptr <= '0;
      rptr <= '0;
      amt <= '0;
      scnt <= '0;
      words <= '0;
      bcnt <= '0;
      dcnt <= '0;
      lane <= '0;
      pack <= '0;
      databus_addr_0 <= '0;
      databus_len_0 <= '0;
      done <= 1'b1;
      overflow <= 1'b0;
      error <= 1'b0;
    end else begin
      state <= state_n;
      if (start) begin
        wptr <= '0;
        rptr <= '0;
        amt <= amount;
        scnt <= '0;
        words <= words_c;
        bcnt <= '0;
        dcnt <= delay0;
        lane <= '0;
        pack <= '0;
        databus_addr_0 <= ext_addr;
        databus_len_0 <= LEN_W'(words_c - (LEN_W+1)'(1));
        done <= 1'b0;
        overflow <= 1'b0;
        error <= 1'b0;
      end else begin
        if (state == DELAY) dcnt <= dcnt - 32'd1;
        if (state == CAPTURE) begin
          scnt <= scnt + AMT_W'(1);
          lane <= push ? '0 : lane + LW'(1);
          pack <= push ? '0 : word_c;
        end
        if (push && !drop) wptr <= wptr + (DEPTH_W+1)'(1);
        if (pop) rptr <= rptr + (DEPTH_W+1)'(1);
        if (pop || drop) bcnt <= bcnt_n;
        if (drop) overflow <= 1'b1;
        if (pop && databus_last_0 && bcnt_n != words) error <= 1'b1;
        if (fin) done <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_lut_result_writer.sv
// tb_lut_result_writer: table, hand-written and randomized checks of lut_result_writer against a packing model
module tb_lut_result_writer;
  localparam int DIFF = 2;
  typedef struct {
    int amt;
    int dly;
    int mode;
    int lastb;
    int beats;
    logic ovf;
    logic err;
    int fv;
  } vec_t;
  logic clk = 0, rst = 1, run = 0, running = 0, disabled = 0;
  logic [31:0] in0 = 0, delay0 = 0, ext_addr = 0, rdata = 0;
  logic [8:0] amount = 0;
  logic ready = 0, last = 0;
  logic valid, done, overflow, error;
  logic [31:0] addr, wdata;
  logic [3:0] wstrb;
  logic [7:0] len;
  int tests = 0, fails = 0;
  vec_t tbl[9];
  always #5 clk = ~clk;
  lut_result_writer dut (
    .clk(clk), .rst(rst), .run(run), .running(running), .disabled(disabled),
    .in0(in0), .delay0(delay0), .ext_addr(ext_addr), .amount(amount),
    .databus_valid_0(valid), .databus_ready_0(ready), .databus_last_0(last),
    .databus_addr_0(addr), .databus_wdata_0(wdata), .databus_wstrb_0(wstrb),
    .databus_len_0(len), .databus_rdata_0(rdata),
    .done(done), .overflow(overflow), .error(error)
  );
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_valid"}, valid, 0);
    chk({tag, "_addr"}, addr, 0);
    chk({tag, "_wdata"}, wdata, 0);
    chk({tag, "_wstrb"}, wstrb, 0);
    chk({tag, "_len"}, len, 0);
    chk({tag, "_overflow"}, overflow, 0);
    chk({tag, "_error"}, error, 0);
  endtask
  // mode: 0 ready high, 1 ready toggles, 2 ready low until capture ends, 3 random ready
  task automatic txn(input int amt, input int dly, input int mode, input int lastb, input logic rnd,
                     input logic [31:0] a, input int exp_beats, input logic exp_ovf,
                     input logic exp_err, input int exp_fv);
    logic [15:0] s[$];
    logic [31:0] ed[$];
    logic [3:0] es[$];
    logic [31:0] d;
    logic [3:0] st;
    int words, beats, fv, last_acc, done_cyc, k;
    words = (amt + DIFF - 1) / DIFF;
    beats = 0;
    fv = -1;
    last_acc = -1;
    done_cyc = -1;
    for (int i = 0; i < amt; i++) s.push_back(rnd ? 16'($urandom) : 16'(i + 1));
    for (int w = 0; w < words; w++) begin
      d = 0;
      st = 0;
      for (int l = 0; l < DIFF; l++)
        if (w * DIFF + l < amt) begin
          d[16*l +: 16] = s[w*DIFF+l];
          st[2*l +: 2] = 2'b11;
        end
      ed.push_back(d);
      es.push_back(st);
    end
    @(posedge clk); #1;
    run = 1; disabled = 0; ext_addr = a; amount = 9'(amt); delay0 = dly; running = 1;
    for (int c = 1; c < 3000 && done_cyc < 0; c++) begin
      @(posedge clk); #1;
      run = 0;
      running = 1'($urandom);
      ext_addr = $urandom;
      amount = 9'($urandom);
      delay0 = $urandom;
      k = c - 1 - dly;
      in0 = {16'($urandom), (k >= 0 && k < amt) ? s[k] : 16'($urandom)};
      ready = mode == 0 ? 1'b1 : mode == 1 ? 1'(c % 2) : mode == 2 ? (c > dly + amt) : ($urandom_range(0, 3) != 0);
      last = lastb > 0 && beats == lastb - 1;
      #1;
      if (done) done_cyc = c;
      else begin
        if (valid && fv < 0) fv = c;
        if (valid && ready) begin
          if (beats < words) begin
            chk("beat_data", wdata, ed[beats]);
            chk("beat_strb", wstrb, es[beats]);
            chk("beat_addr", addr, a);
            chk("beat_len", len, words - 1);
          end else chk("extra_beat", beats, words - 1);
          beats++;
          last_acc = c;
        end
      end
    end
    last = 0;
    ready = 0;
    chk("done_reached", done_cyc > 0, 1);
    chk("beats", beats, exp_beats);
    chk("done_latency", done_cyc - last_acc, 1);
    chk("overflow", overflow, exp_ovf);
    chk("error", error, exp_err);
    if (exp_fv >= 0) chk("first_valid", fv, exp_fv);
  endtask
  initial begin
    tbl[0] = '{8, 0, 0, 0, 4, 1'b0, 1'b0, 3};
    tbl[1] = '{3, 5, 0, 0, 2, 1'b0, 1'b0, 8};
    tbl[2] = '{40, 0, 2, 0, 16, 1'b1, 1'b0, -1};
    tbl[3] = '{16, 2, 1, 0, 8, 1'b0, 1'b0, -1};
    tbl[4] = '{8, 1, 0, 2, 4, 1'b0, 1'b1, -1};
    tbl[5] = '{8, 0, 0, 4, 4, 1'b0, 1'b0, -1};
    tbl[6] = '{1, 0, 0, 0, 1, 1'b0, 1'b0, 2};
    tbl[7] = '{32, 3, 2, 0, 16, 1'b0, 1'b0, -1};
    tbl[8] = '{34, 0, 2, 0, 16, 1'b1, 1'b0, -1};
    repeat (3) @(posedge clk);
    #1 rst = 0;
    #1 chk_reset("reset");
    @(posedge clk); #1;
    run = 1; amount = 0; ext_addr = 32'h55;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      run = 0;
      #1;
      chk("zero_amount_done", done, 1);
      chk("zero_amount_valid", valid, 0);
    end
    @(posedge clk); #1;
    run = 1; disabled = 1; amount = 4;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      run = 0;
      #1;
      chk("disabled_done", done, 1);
      chk("disabled_valid", valid, 0);
    end
    disabled = 0;
    for (int i = 0; i < 9; i++)
      txn(tbl[i].amt, tbl[i].dly, tbl[i].mode, tbl[i].lastb, 1'b0, 32'h1000 + 32'(i * 16),
          tbl[i].beats, tbl[i].ovf, tbl[i].err, tbl[i].fv);
    @(posedge clk); #1;
    run = 1; amount = 8; delay0 = 0; ext_addr = 32'h40; ready = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      run = 0;
      in0 = $urandom;
    end
    #1;
    chk("restart_done_low", done, 0);
    chk("restart_old_valid", valid, 1);
    txn(4, 0, 0, 0, 1'b1, 32'h100, 2, 1'b0, 1'b0, 3);
    @(posedge clk); #1;
    run = 1; amount = 8; delay0 = 0; ext_addr = 32'hABC0; ready = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      run = 0;
      in0 = $urandom;
    end
    #1;
    chk("mid_capture_valid", valid, 1);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    chk_reset("mid_capture_reset");
    for (int r = 0; r < 20; r++) begin
      int amt, m;
      amt = $urandom_range(1, 32);
      m = $urandom_range(0, 2);
      txn(amt, $urandom_range(0, 6), m == 2 ? 3 : m, 0, 1'b1, $urandom, (amt + 1) / 2, 1'b0, 1'b0, -1);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
